db_req_arb: RTL

- Arbitrates two requesters for the single lookup/update port of the flow database: requester 0 is the network ingress lookup path, requester 1 is the control-plane insert/delete path.
- Paces issues so the database's CRC hash pipeline sees the minimum idle gap it needs.
- Tracks outstanding operations in an in-order tag FIFO.
- Steers each database result back to the requester that issued it.

---
 rtl/db_pkg.sv | 21 ++
 rtl/db_tag_fifo.sv | 50 +++++
 rtl/db_req_arb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/db_pkg.sv
// Shared constants and types for the flow-database request arbiter slice.
package db_pkg;

    localparam int KEY_LEN  = 96;
    localparam int FLAG_LEN = 4;

    localparam logic REQ_NET = 1'b0;
    localparam logic REQ_CTL = 1'b1;

    localparam logic [FLAG_LEN-1:0] SUSPECTION = 4'd1;
    localparam logic [FLAG_LEN-1:0] ARREST     = 4'd2;
    localparam logic [FLAG_LEN-1:0] FILTERED   = 4'd3;
    localparam logic [FLAG_LEN-1:0] EXPIRED    = 4'd4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_GAP
    } arb_state_e;

endpackage

// File: rtl/db_tag_fifo.sv
// In-order FIFO of requester ids for operations issued to the database and not yet answered.
module db_tag_fifo
    import db_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   push_id_i,
    input  logic                   pop_i,
    output logic                   head_id_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign head_id_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/db_req_arb.sv
// Round-robin arbiter for the flow-database port: paces issues for the hash pipeline
// and steers each in-order result back to the requester that issued it.
module db_req_arb
    import db_pkg::*;
#(
    parameter int KEY_SIZE  = KEY_LEN,
    parameter int FLAG_SIZE = FLAG_LEN,
    parameter int MAX_OUTST = 8,
    parameter int ISSUE_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid_i,
    output logic                       req0_ready_o,
    input  logic [KEY_SIZE-1:0]        req0_key_i,
    input  logic [FLAG_SIZE-1:0]       req0_flag_i,
    input  logic                       req1_valid_i,
    output logic                       req1_ready_o,
    input  logic [KEY_SIZE-1:0]        req1_key_i,
    input  logic [FLAG_SIZE-1:0]       req1_flag_i,
    output logic                       db_valid_o,
    output logic [KEY_SIZE-1:0]        db_key_o,
    output logic [FLAG_SIZE-1:0]       db_flag_o,
    input  logic                       db_out_valid_i,
    input  logic [FLAG_SIZE-1:0]       db_out_flag_i,
    output logic                       rsp0_valid_o,
    output logic                       rsp1_valid_o,
    output logic [FLAG_SIZE-1:0]       rsp_flag_o,
    output logic [$clog2(MAX_OUTST):0] outst_o,
    output logic                       err_orphan_o
);
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP + 1) : 1;

    arb_state_e           state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 prio_q, prio_d;
    logic                 gnt_id_q, gnt_id_d;
    logic [KEY_SIZE-1:0]  db_key_q, db_key_d;
    logic [FLAG_SIZE-1:0] db_flag_q, db_flag_d;
    logic [FLAG_SIZE-1:0] rsp_flag_q, rsp_flag_d;
    logic                 rsp0_q, rsp0_d, rsp1_q, rsp1_d, orphan_q, orphan_d;

    logic grant, win_id, push, pop, head_id, fifo_empty, fifo_full;

    // prio_q names the requester that wins a tie; a lone requester always wins.
    assign win_id = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
    assign grant  = !rst && (state_q == ARB_IDLE) && !fifo_full && (req0_valid_i || req1_valid_i);

    assign req0_ready_o = grant && (win_id == REQ_NET);
    assign req1_ready_o = grant && (win_id == REQ_CTL);
    assign push         = (state_q == ARB_ISSUE);
    assign pop          = db_out_valid_i && !fifo_empty;

    assign db_valid_o   = (state_q == ARB_ISSUE) && !rst;
    assign db_key_o     = db_key_q;
    assign db_flag_o    = db_flag_q;
    assign rsp0_valid_o = rsp0_q;
    assign rsp1_valid_o = rsp1_q;
    assign rsp_flag_o   = rsp_flag_q;
    assign err_orphan_o = orphan_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (ISSUE_GAP > 0) begin
                    state_d   = ARB_GAP;
                    gap_cnt_d = GAP_W'(ISSUE_GAP);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_d <= GAP_W'(1)) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        prio_d     = prio_q;
        gnt_id_d   = gnt_id_q;
        db_key_d   = db_key_q;
        db_flag_d  = db_flag_q;
        rsp_flag_d = rsp_flag_q;
        if (grant) begin
            prio_d    = ~win_id;
            gnt_id_d  = win_id;
            db_key_d  = (win_id == REQ_CTL) ? req1_key_i  : req0_key_i;
            db_flag_d = (win_id == REQ_CTL) ? req1_flag_i : req0_flag_i;
        end
        if (pop) rsp_flag_d = db_out_flag_i;
        rsp0_d   = pop && (head_id == REQ_NET);
        rsp1_d   = pop && (head_id == REQ_CTL);
        orphan_d = db_out_valid_i && fifo_empty;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gap_cnt_q  <= '0;
            prio_q     <= REQ_NET;
            gnt_id_q   <= REQ_NET;
            db_key_q   <= '0;
            db_flag_q  <= '0;
            rsp_flag_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            prio_q     <= prio_d;
            gnt_id_q   <= gnt_id_d;
            db_key_q   <= db_key_d;
            db_flag_q  <= db_flag_d;
            rsp_flag_q <= rsp_flag_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            orphan_q   <= orphan_d;
        end
    end

    db_tag_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .push_id_i(gnt_id_q),
        .pop_i    (pop),
        .head_id_o(head_id),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full),
        .count_o  (outst_o)
    );

endmodule
